i2c_byte_ctrl: RTL

//  Byte-level I2C master controller sitting directly upstream of i2c_phy.

---
 rtl/i2c_pkg.sv | 27 ++
 rtl/i2c_bit_issuer.sv | 98 +++++++++
 rtl/i2c_byte_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the byte-level I2C master: FSM states, bit sub-phases,
// single-bit request kinds, ACK polarity and the field-skipping helper.
// No ports; imported by i2c_bit_issuer and i2c_byte_ctrl.
package i2c_pkg;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_WBIT, S_WACK, S_RBIT, S_RACK, S_STOP, S_DONE
   } state_e;

   typedef enum logic {PH_ISSUE, PH_WAIT} phase_e;

   typedef enum logic [1:0] {BK_START, BK_STOP, BK_WRITE, BK_READ} bit_kind_e;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

   // First state with its field set; used at acceptance and after START.
   function automatic state_e first_state(input logic s, input logic w,
                                          input logic r, input logic p);
      if (s)      return S_START;
      else if (w) return S_WBIT;
      else if (r) return S_RBIT;
      else if (p) return S_STOP;
      else        return S_DONE;
   endfunction

endpackage

// File: rtl/i2c_bit_issuer.sv
// Purpose: turns one bit request into a registered i2c_phy pulse and tracks phy_busy high->low.
// Latency: phy pulse 1 cycle after req; bit_done in the cycle phy_busy is first seen low.
// Backpressure: caller only raises req while phy_busy is low; watchdog aborts a stuck bit.
// Ports: req/req_kind/req_tx in from the byte FSM; phy_* pulses and phy_tx_data out;
//        phy_busy/phy_rx_data_reg in; bit_done/bit_rx/bit_timeout back to the byte FSM.
module i2c_bit_issuer
   import i2c_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic [1:0] req_kind,
   input  logic       req_tx,
   input  logic       phy_busy,
   input  logic       phy_rx_data_reg,
   output logic       phy_start_bit,
   output logic       phy_stop_bit,
   output logic       phy_write_bit,
   output logic       phy_read_bit,
   output logic       phy_tx_data,
   output logic       phy_release_bus,
   output logic       bit_done,
   output logic       bit_rx,
   output logic       bit_timeout
);

   logic        start_q, start_d, stop_q, stop_d, write_q, write_d, read_q, read_d;
   logic        tx_q, tx_d, release_q, release_d;
   logic        active_q, active_d, seen_hi_q, seen_hi_d;
   logic [31:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         start_q   <= 1'b0;
         stop_q    <= 1'b0;
         write_q   <= 1'b0;
         read_q    <= 1'b0;
         tx_q      <= 1'b0;
         release_q <= 1'b0;
         active_q  <= 1'b0;
         seen_hi_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         start_q   <= start_d;
         stop_q    <= stop_d;
         write_q   <= write_d;
         read_q    <= read_d;
         tx_q      <= tx_d;
         release_q <= release_d;
         active_q  <= active_d;
         seen_hi_q <= seen_hi_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      start_d   = req && (req_kind == BK_START);
      stop_d    = req && (req_kind == BK_STOP);
      write_d   = req && (req_kind == BK_WRITE);
      read_d    = req && (req_kind == BK_READ);
      tx_d      = req ? req_tx : tx_q;
      release_d = 1'b0;
      active_d  = active_q;
      seen_hi_d = seen_hi_q;
      cnt_d     = cnt_q;
      // The bit ends on the first low cycle after phy_busy was seen high.
      bit_done  = active_q && seen_hi_q && !phy_busy;
      if (req) begin
         active_d  = 1'b1;
         seen_hi_d = 1'b0;
         cnt_d     = '0;
      end else if (active_q) begin
         if (bit_done) begin
            active_d = 1'b0;
         end else begin
            if (phy_busy) seen_hi_d = 1'b1;
            cnt_d = cnt_q + 32'd1;
            // Counter is 0 in the pulse cycle, so release lands TIMEOUT_CYCLES after it.
            if ((TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1)) begin
               release_d = 1'b1;
               active_d  = 1'b0;
            end
         end
      end
   end

   assign phy_start_bit   = start_q;
   assign phy_stop_bit    = stop_q;
   assign phy_write_bit   = write_q;
   assign phy_read_bit    = read_q;
   assign phy_tx_data     = tx_q;
   assign phy_release_bus = release_q;
   assign bit_rx          = phy_rx_data_reg;
   assign bit_timeout     = release_q;

endmodule

// File: rtl/i2c_byte_ctrl.sv
// Purpose: byte-level I2C master; splits START/WRITE/READ/STOP commands into i2c_phy bit requests.
// Latency: done 1 cycle after acceptance for illegal/empty commands, else after the last bit completes.
// Backpressure: cmd_ready only in IDLE; one command in flight; each bit waits for phy_busy to drop.
// Ports: cmd_* valid/ready command in; rx_data/rx_valid/ack_received/done/cmd_error/busy status out;
//        phy_* request pulses out, phy_busy/bus_control_reg/phy_rx_data_reg in from i2c_phy.
module i2c_byte_ctrl
   import i2c_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_start,
   input  logic       cmd_write,
   input  logic       cmd_read,
   input  logic       cmd_stop,
   input  logic [7:0] cmd_data,
   input  logic       cmd_ack,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       ack_received,
   output logic       done,
   output logic       cmd_error,
   output logic       busy,
   output logic       phy_start_bit,
   output logic       phy_stop_bit,
   output logic       phy_write_bit,
   output logic       phy_read_bit,
   output logic       phy_tx_data,
   output logic       phy_release_bus,
   input  logic       phy_busy,
   input  logic       bus_control_reg,
   input  logic       phy_rx_data_reg
);

   state_e     state_q, state_d;
   phase_e     phase_q, phase_d;
   logic       wr_q, wr_d, rd_q, rd_d, stp_q, stp_d, ack_q, ack_d, err_q, err_d;
   logic [7:0] sh_q, sh_d, rx_data_q, rx_data_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       rx_valid_q, rx_valid_d, ack_rcv_q, ack_rcv_d;
   logic       bit_req, bit_tx, bit_done, bit_rx, bit_timeout, stop_skip;
   logic [1:0] bit_kind;

   i2c_bit_issuer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_issuer (
      .clk(clk), .rst(rst),
      .req(bit_req), .req_kind(bit_kind), .req_tx(bit_tx),
      .phy_busy(phy_busy), .phy_rx_data_reg(phy_rx_data_reg),
      .phy_start_bit(phy_start_bit), .phy_stop_bit(phy_stop_bit),
      .phy_write_bit(phy_write_bit), .phy_read_bit(phy_read_bit),
      .phy_tx_data(phy_tx_data), .phy_release_bus(phy_release_bus),
      .bit_done(bit_done), .bit_rx(bit_rx), .bit_timeout(bit_timeout)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         phase_q    <= PH_ISSUE;
         wr_q       <= 1'b0;
         rd_q       <= 1'b0;
         stp_q      <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         sh_q       <= '0;
         bit_cnt_q  <= 3'd7;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         ack_rcv_q  <= NACK;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         stp_q      <= stp_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         sh_q       <= sh_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         ack_rcv_q  <= ack_rcv_d;
      end
   end

   // A STOP with nobody holding the bus is dropped without touching the phy.
   assign stop_skip = (state_q == S_STOP) && !bus_control_reg;

   // Next-state and datapath
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      wr_d       = wr_q;
      rd_d       = rd_q;
      stp_d      = stp_q;
      ack_d      = ack_q;
      err_d      = err_q;
      sh_d       = sh_q;
      bit_cnt_d  = bit_cnt_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      ack_rcv_d  = ack_rcv_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               wr_d      = cmd_write;
               rd_d      = cmd_read;
               stp_d     = cmd_stop;
               ack_d     = cmd_ack;
               sh_d      = cmd_data;
               bit_cnt_d = 3'd7;
               phase_d   = PH_ISSUE;
               err_d     = 1'b0;
               if ((cmd_write && cmd_read) ||
                   ((cmd_write || cmd_read) && !cmd_start && !bus_control_reg)) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d = first_state(cmd_start, cmd_write, cmd_read, cmd_stop);
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         default: begin
            if (phase_q == PH_ISSUE) begin
               if (stop_skip)      state_d = S_DONE;
               else if (!phy_busy) phase_d = PH_WAIT;
            end else if (bit_timeout) begin
               state_d = S_DONE;
               phase_d = PH_ISSUE;
               err_d   = 1'b1;
            end else if (bit_done) begin
               phase_d = PH_ISSUE;
               case (state_q)
                  S_START: state_d = first_state(1'b0, wr_q, rd_q, stp_q);
                  S_WBIT, S_RBIT: begin
                     sh_d = {sh_q[6:0], (state_q == S_RBIT) ? bit_rx : 1'b0};
                     if (bit_cnt_q == 3'd0) state_d = (state_q == S_WBIT) ? S_WACK : S_RACK;
                     else                   bit_cnt_d = bit_cnt_q - 3'd1;
                  end
                  S_WACK: begin
                     ack_rcv_d = bit_rx;
                     state_d   = stp_q ? S_STOP : S_DONE;
                  end
                  S_RACK: begin
                     rx_data_d  = sh_q;
                     rx_valid_d = 1'b1;
                     state_d    = stp_q ? S_STOP : S_DONE;
                  end
                  default: state_d = S_DONE;
               endcase
            end
         end
      endcase
   end

   // Outputs
   always_comb begin
      bit_req  = 1'b0;
      bit_kind = BK_START;
      bit_tx   = 1'b0;
      case (state_q)
         S_START: bit_kind = BK_START;
         S_STOP:  bit_kind = BK_STOP;
         S_WBIT:  begin bit_kind = BK_WRITE; bit_tx = sh_q[7]; end
         S_RACK:  begin bit_kind = BK_WRITE; bit_tx = ack_q;   end
         default: bit_kind = BK_READ;
      endcase
      if ((state_q != S_IDLE) && (state_q != S_DONE) && (phase_q == PH_ISSUE) &&
          !phy_busy && !stop_skip)
         bit_req = 1'b1;
   end

   assign cmd_ready    = (state_q == S_IDLE);
   assign busy         = (state_q != S_IDLE);
   assign done         = (state_q == S_DONE);
   assign cmd_error    = (state_q == S_DONE) && err_q;
   assign rx_data      = rx_data_q;
   assign rx_valid     = rx_valid_q;
   assign ack_received = ack_rcv_q;

endmodule
